mm_line_fetcher: RTL
====================

Name: mm_line_fetcher

Overview:
- Main-memory-side read sequencer directly downstream of the L1 instruction cache controller.
- Consumes the controller's re_mm / reset_mm and fetches one cache line, one word at a time, from a fixed-latency synchronous main memory.
- Presents each word with a one-cycle mem_valid_mm pulse, which the controller and cache-line buffer use to advance (we_cl / next_cl).

Parameters:
- ADDR_WIDTH, 32, word-address width of miss_addr and mem_addr.
- DATA_WIDTH, 32, memory word width.
- WORDS_PER_LINE, 4, words per cache line; power of 2, at least 2; OFF = log2(WORDS_PER_LINE).
- MEM_LATENCY, 3, cycles from a mem_rd pulse to valid mem_rdata; at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- re_mm  in  1  fetch enable from the cache controller.
- reset_mm  in  1  restart pulse; latches miss_addr and clears progress.
- miss_addr  in  ADDR_WIDTH  word address of the missing instruction.
- mem_rd  out  1  one-cycle read strobe to main memory.
- mem_addr  out  ADDR_WIDTH  read address; valid while mem_rd=1.
- mem_rdata  in  DATA_WIDTH  memory data, valid exactly MEM_LATENCY cycles after mem_rd.
- mm_data  out  DATA_WIDTH  captured word; stable from its mem_valid_mm pulse until the next capture.
- mem_valid_mm  out  1  one-cycle pulse: mm_data holds a new word.
- word_idx  out  OFF  index of the next word to fetch.
- line_done  out  1  high once all words of the line have been delivered.
- busy  out  1  high in ISSUE, WAIT and VALID.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state goes to IDLE.
  - All outputs go to 0: mem_rd, mem_addr, mm_data, mem_valid_mm, word_idx, line_done, busy.
  - base_addr and lat_cnt go to 0.
  - Reset has priority over everything.
- reset_mm=1 (reset inactive):
  - base_addr <= {miss_addr[ADDR_WIDTH-1:OFF], OFF'b0}; word_idx <= 0; line_done <= 0; state <= IDLE.
  - This applies in any state, including mid-burst. An in-flight read is abandoned and its returning data is never captured.
  - reset_mm has priority over re_mm in the same cycle.
- States:
  - IDLE: if re_mm=1, go to ISSUE.
  - ISSUE: mem_rd=1; mem_addr = base_addr | word_idx; lat_cnt <= MEM_LATENCY-1; go to WAIT.
  - WAIT: lasts exactly MEM_LATENCY cycles. If lat_cnt=0, mm_data <= mem_rdata and go to VALID; otherwise lat_cnt decrements.
  - VALID: mem_valid_mm=1 for one cycle; word_idx increments.
    - If word_idx was WORDS_PER_LINE-1: word_idx wraps to 0, line_done <= 1, go to DONE.
    - Else if re_mm=1: go to ISSUE.
    - Else: go to IDLE.
  - DONE: line_done=1, no memory traffic, re_mm ignored. Leave only via reset_mm (to IDLE) or reset.
- re_mm dropping mid-word does not cancel the in-flight read. The word completes, with its VALID pulse, then the block pauses in IDLE. Raising re_mm again resumes at word_idx.
- Timing:
  - Per-word period while re_mm stays high: MEM_LATENCY+2 cycles.
  - First VALID comes MEM_LATENCY+2 cycles after the first cycle re_mm is seen high in IDLE.
- At most one outstanding read; mem_rd is never asserted outside ISSUE.
- mem_valid_mm is never high in two consecutive cycles.
- mem_valid_mm is high only in VALID, so at most WORDS_PER_LINE pulses occur per reset_mm.
- Outputs are driven from registered state or registers (Moore); no combinational path from re_mm to mem_rd.

Test Plan:
- Reset: hold reset=0 for 2 cycles with re_mm=1 -> all outputs 0, state IDLE, no mem_rd.
- Basic line (MEM_LATENCY=3, WORDS_PER_LINE=4): pulse reset_mm with miss_addr=0x1236, then hold re_mm=1 from cycle 0; memory returns data=addr^0xA5A5A5A5 -> mem_rd at cycles 1, 6, 11, 16 with mem_addr 0x1234..0x1237; mem_valid_mm at cycles 5, 10, 15, 20 with matching mm_data; line_done=1 from cycle 21.
- Pause: drop re_mm in cycle 7 (during WAIT of word 1) -> word 1 still valid at cycle 10, block idles with word_idx=2; re-raise re_mm at cycle 14 -> mem_rd at cycle 15 with addr 0x1236.
- Abort: assert reset_mm in cycle 8 with miss_addr=0x2000 -> no valid at cycle 10; the next burst fetches 0x2000..0x2003, and the stale word 0x1235 is never presented.
- DONE hold: after line_done=1, hold re_mm=1 for 10 cycles -> no mem_rd, no mem_valid_mm; a reset_mm pulse clears line_done next cycle.
- Priority: reset=0 and reset_mm=1 in the same cycle during WAIT -> reset wins; base_addr=0, all outputs 0.

Source files
------------

// File: rtl/mm_line_fetcher_if.sv
// Bus bundle between the L1 I-cache controller / main memory side and the
// main-memory line fetcher.
interface mm_line_fetcher_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4
);
    localparam int OFF = $clog2(WORDS_PER_LINE);

    logic                  re_mm;
    logic                  reset_mm;
    logic [ADDR_WIDTH-1:0] miss_addr;
    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] mm_data;
    logic                  mem_valid_mm;
    logic [OFF-1:0]        word_idx;
    logic                  line_done;
    logic                  busy;

    // Controller + memory side
    modport master (
        output re_mm, reset_mm, miss_addr, mem_rdata,
        input  mem_rd, mem_addr, mm_data, mem_valid_mm, word_idx, line_done, busy
    );

    // Fetcher side
    modport slave (
        input  re_mm, reset_mm, miss_addr, mem_rdata,
        output mem_rd, mem_addr, mm_data, mem_valid_mm, word_idx, line_done, busy
    );
endinterface

// File: rtl/mm_line_fetcher.sv
// Fetches one cache line word by word from a fixed-latency main memory and
// presents each word with a one-cycle mem_valid_mm pulse.
module mm_line_fetcher #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int MEM_LATENCY    = 3
) (
    input  logic               clk,
    input  logic               reset,
    mm_line_fetcher_if.slave   bus
);
    localparam int OFF   = $clog2(WORDS_PER_LINE);
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [LAT_W-1:0]      LAT_LOAD  = LAT_W'(MEM_LATENCY - 1);
    localparam logic [OFF-1:0]        LAST_IDX  = OFF'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_r,     state_s;
    logic [ADDR_WIDTH-1:0] base_r,      base_s;
    logic [OFF-1:0]        word_idx_r,  word_idx_s;
    logic                  line_done_r, line_done_s;
    logic [LAT_W-1:0]      lat_cnt_r,   lat_cnt_s;
    logic [DATA_WIDTH-1:0] mm_data_r,   mm_data_s;
    logic                  mem_rd_r,    mem_rd_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r,  mem_addr_s;
    logic                  valid_r,     valid_s;
    logic                  busy_r,      busy_s;

    // Next-state and next-output computation
    always_comb begin
        state_s     = state_r;
        base_s      = base_r;
        word_idx_s  = word_idx_r;
        line_done_s = line_done_r;
        lat_cnt_s   = lat_cnt_r;
        mm_data_s   = mm_data_r;

        if (bus.reset_mm) begin
            // Restart abandons any in-flight read; its data is never captured
            base_s      = bus.miss_addr & LINE_MASK;
            word_idx_s  = {OFF{1'b0}};
            line_done_s = 1'b0;
            state_s     = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.re_mm) begin
                        state_s = S_ISSUE;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_ISSUE: begin
                    lat_cnt_s = LAT_LOAD;
                    state_s   = S_WAIT;
                end
                S_WAIT: begin
                    if (lat_cnt_r == {LAT_W{1'b0}}) begin
                        mm_data_s = bus.mem_rdata;
                        state_s   = S_VALID;
                    end else begin
                        lat_cnt_s = lat_cnt_r - LAT_W'(1);
                    end
                end
                S_VALID: begin
                    word_idx_s = word_idx_r + OFF'(1);
                    if (word_idx_r == LAST_IDX) begin
                        line_done_s = 1'b1;
                        state_s     = S_DONE;
                    end else if (bus.re_mm) begin
                        state_s = S_ISSUE;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_DONE: begin
                    line_done_s = 1'b1;
                    state_s     = S_DONE;
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end

        // Outputs are decoded from the next state so they register in step with it
        mem_rd_s   = (state_s == S_ISSUE);
        mem_addr_s = mem_rd_s ? (base_s | ADDR_WIDTH'(word_idx_s)) : mem_addr_r;
        valid_s    = (state_s == S_VALID);
        busy_s     = (state_s == S_ISSUE) || (state_s == S_WAIT) || (state_s == S_VALID);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            base_r      <= {ADDR_WIDTH{1'b0}};
            word_idx_r  <= {OFF{1'b0}};
            line_done_r <= 1'b0;
            lat_cnt_r   <= {LAT_W{1'b0}};
            mm_data_r   <= {DATA_WIDTH{1'b0}};
            mem_rd_r    <= 1'b0;
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            base_r      <= base_s;
            word_idx_r  <= word_idx_s;
            line_done_r <= line_done_s;
            lat_cnt_r   <= lat_cnt_s;
            mm_data_r   <= mm_data_s;
            mem_rd_r    <= mem_rd_s;
            mem_addr_r  <= mem_addr_s;
            valid_r     <= valid_s;
            busy_r      <= busy_s;
        end
    end

    assign bus.mem_rd       = mem_rd_r;
    assign bus.mem_addr     = mem_addr_r;
    assign bus.mm_data      = mm_data_r;
    assign bus.mem_valid_mm = valid_r;
    assign bus.word_idx     = word_idx_r;
    assign bus.line_done    = line_done_r;
    assign bus.busy         = busy_r;
endmodule
